vgachargen_mem_ctrl: RTL and testbench

//  Single-requester access sequencer for the text-mode memories: char map, colour map, writable glyph table.

---
 rtl/vgachargen_pkg.sv | 45 ++++
 rtl/vgachargen_mem_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_vgachargen_mem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vgachargen_pkg.sv
// Shared constants, region and state encodings, and 32-bit slice helpers for
// the 128-bit glyph rows used by the text-mode memory sequencer.
package vgachargen_pkg;

  localparam int COLS         = 80;
  localparam int ROWS         = 30;
  localparam int GLYPH_CNT    = 128;
  localparam int ADDR_W       = 14;
  localparam int CH_MAP_DEPTH = COLS * ROWS;
  localparam int MAP_AW       = $clog2(CH_MAP_DEPTH);
  localparam int GLYPH_AW     = $clog2(GLYPH_CNT);

  typedef enum logic [1:0] {
    REGION_CH_MAP  = 2'd0,
    REGION_COL_MAP = 2'd1,
    REGION_GLYPH   = 2'd2,
    REGION_CTRL    = 2'd3
  } region_e;

  typedef logic [2:0] state_e;
  localparam state_e STATE_IDLE   = 3'd0;
  localparam state_e STATE_RD     = 3'd1;
  localparam state_e STATE_RMW_RD = 3'd2;
  localparam state_e STATE_RMW_WR = 3'd3;
  localparam state_e STATE_FILL   = 3'd4;

  localparam logic [11:0] CTRL_FILL_OFS   = 12'd0;
  localparam int          CTRL_START_BIT  = 16;
  localparam int          CTRL_COLOUR_LSB = 8;
  localparam int          CTRL_CHAR_LSB   = 0;

  function automatic logic [31:0] get_slice(input logic [127:0] row, input logic [1:0] slice);
    return row[{slice, 5'b00000} +: 32];
  endfunction

  // Slice 0 is row bits [31:0]; every other bit of the row is preserved.
  function automatic logic [127:0] merge_slice(input logic [127:0] row, input logic [1:0] slice,
                                               input logic [31:0] word);
    logic [127:0] res;
    res = row;
    res[{slice, 5'b00000} +: 32] = word;
    return res;
  endfunction

endpackage

// File: rtl/vgachargen_mem_ctrl.sv
// Bus access sequencer for the char map, colour map and writable glyph table:
// single-word map accesses, glyph-row read-modify-write and a full-screen fill engine.
module vgachargen_mem_ctrl
  import vgachargen_pkg::*;
(
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                req_i,
  output logic                ready_o,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [31:0]         wdata_i,
  output logic                rsp_valid_o,
  output logic [31:0]         rdata_o,
  output logic                rsp_err_o,
  output logic [MAP_AW-1:0]   ch_map_addr_o,
  output logic [7:0]          ch_map_data_o,
  output logic                ch_map_wen_o,
  input  logic [7:0]          ch_map_data_i,
  output logic [MAP_AW-1:0]   col_map_addr_o,
  output logic [7:0]          col_map_data_o,
  output logic                col_map_wen_o,
  input  logic [7:0]          col_map_data_i,
  output logic [GLYPH_AW-1:0] ch_t_rw_addr_o,
  output logic [127:0]        ch_t_rw_data_o,
  output logic                ch_t_rw_wen_o,
  input  logic [127:0]        ch_t_rw_data_i,
  output logic                fill_busy_o
);

  localparam logic [MAP_AW-1:0] MAP_ONE  = MAP_AW'(1);
  localparam logic [MAP_AW-1:0] MAP_LAST = MAP_AW'(CH_MAP_DEPTH - 1);

  state_e              state_r;
  logic                ready_r, rsp_valid_r, rsp_err_r, rd_sel_r;
  logic [31:0]         rdata_r, wdata_r;
  region_e             region_r;
  logic [1:0]          slice_r;
  logic [MAP_AW-1:0]   ch_addr_r, col_addr_r, fill_idx_r;
  logic [7:0]          ch_data_r, col_data_r;
  logic                ch_wen_r, col_wen_r, glyph_wen_r, fill_busy_r;
  logic [GLYPH_AW-1:0] glyph_addr_r;

  region_e             region_s;
  logic [11:0]         offset_s;
  logic                ofs_ok_s, accept_s;
  logic [MAP_AW-1:0]   fill_nxt_s;
  logic [31:0]         rdata_s;
  logic [127:0]        glyph_wdata_s;

  assign region_s   = region_e'(addr_i[13:12]);
  assign offset_s   = addr_i[11:0];
  assign accept_s   = req_i & ready_r;
  assign fill_nxt_s = fill_idx_r + MAP_ONE;

  // Offset range check for the addressed region.
  always_comb begin
    ofs_ok_s = 1'b0;
    case (region_s)
      REGION_CH_MAP:  ofs_ok_s = (offset_s < 12'(CH_MAP_DEPTH));
      REGION_COL_MAP: ofs_ok_s = (offset_s < 12'(CH_MAP_DEPTH));
      REGION_GLYPH:   ofs_ok_s = (offset_s[11:9] == 3'b000);
      REGION_CTRL:    ofs_ok_s = (offset_s == CTRL_FILL_OFS);
      default:        ofs_ok_s = 1'b0;
    endcase
  end

  // Sequencer: request decode, read/RMW latency states and the fill engine.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_r      <= STATE_IDLE;
      ready_r      <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      rd_sel_r     <= 1'b0;
      region_r     <= REGION_CH_MAP;
      slice_r      <= 2'b00;
      wdata_r      <= 32'h0000_0000;
      ch_addr_r    <= {MAP_AW{1'b0}};
      ch_data_r    <= 8'h00;
      ch_wen_r     <= 1'b0;
      col_addr_r   <= {MAP_AW{1'b0}};
      col_data_r   <= 8'h00;
      col_wen_r    <= 1'b0;
      glyph_addr_r <= {GLYPH_AW{1'b0}};
      glyph_wen_r  <= 1'b0;
      fill_busy_r  <= 1'b0;
      fill_idx_r   <= {MAP_AW{1'b0}};
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      rd_sel_r    <= 1'b0;
      ch_wen_r    <= 1'b0;
      col_wen_r   <= 1'b0;
      glyph_wen_r <= 1'b0;
      case (state_r)
        STATE_IDLE: begin
          if (accept_s && !ofs_ok_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
          end else if (accept_s) begin
            region_r <= region_s;
            case (region_s)
              REGION_CH_MAP: begin
                ch_addr_r <= offset_s[MAP_AW-1:0];
                ch_data_r <= wdata_i[7:0];
                if (we_i) begin
                  ch_wen_r    <= 1'b1;
                  rsp_valid_r <= 1'b1;
                end else begin
                  state_r <= STATE_RD;
                  ready_r <= 1'b0;
                end
              end
              REGION_COL_MAP: begin
                col_addr_r <= offset_s[MAP_AW-1:0];
                col_data_r <= wdata_i[7:0];
                if (we_i) begin
                  col_wen_r   <= 1'b1;
                  rsp_valid_r <= 1'b1;
                end else begin
                  state_r <= STATE_RD;
                  ready_r <= 1'b0;
                end
              end
              REGION_GLYPH: begin
                glyph_addr_r <= offset_s[8:2];
                slice_r      <= offset_s[1:0];
                wdata_r      <= wdata_i;
                ready_r      <= 1'b0;
                state_r      <= we_i ? STATE_RMW_RD : STATE_RD;
              end
              REGION_CTRL: begin
                rsp_valid_r <= 1'b1;
                if (!we_i) begin
                  rdata_r <= {31'b0, fill_busy_r};
                end else if (wdata_i[CTRL_START_BIT]) begin
                  state_r     <= STATE_FILL;
                  ready_r     <= 1'b0;
                  fill_busy_r <= 1'b1;
                  fill_idx_r  <= {MAP_AW{1'b0}};
                  ch_addr_r   <= {MAP_AW{1'b0}};
                  col_addr_r  <= {MAP_AW{1'b0}};
                  ch_data_r   <= wdata_i[CTRL_CHAR_LSB +: 8];
                  col_data_r  <= wdata_i[CTRL_COLOUR_LSB +: 8];
                  ch_wen_r    <= 1'b1;
                  col_wen_r   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        STATE_RD: begin
          rsp_valid_r <= 1'b1;
          rd_sel_r    <= 1'b1;
          state_r     <= STATE_IDLE;
          ready_r     <= 1'b1;
        end
        STATE_RMW_RD: begin
          glyph_wen_r <= 1'b1;
          rsp_valid_r <= 1'b1;
          state_r     <= STATE_RMW_WR;
        end
        STATE_RMW_WR: begin
          state_r <= STATE_IDLE;
          ready_r <= 1'b1;
        end
        STATE_FILL: begin
          // The index stops at the last cell; leaving FILL is the only way out.
          if (fill_idx_r == MAP_LAST) begin
            state_r     <= STATE_IDLE;
            ready_r     <= 1'b1;
            fill_busy_r <= 1'b0;
          end else begin
            fill_idx_r <= fill_nxt_s;
            ch_addr_r  <= fill_nxt_s;
            col_addr_r <= fill_nxt_s;
            ch_wen_r   <= 1'b1;
            col_wen_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= STATE_IDLE;
          ready_r     <= 1'b1;
          fill_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // BRAM read data only exists in the response cycle, so it is steered straight out.
  always_comb begin
    rdata_s = rdata_r;
    if (rd_sel_r) begin
      case (region_r)
        REGION_CH_MAP:  rdata_s = {24'h00_0000, ch_map_data_i};
        REGION_COL_MAP: rdata_s = {24'h00_0000, col_map_data_i};
        REGION_GLYPH:   rdata_s = get_slice(ch_t_rw_data_i, slice_r);
        default:        rdata_s = rdata_r;
      endcase
    end else begin
      rdata_s = rdata_r;
    end
  end

  // Merged glyph row for the RMW write cycle.
  always_comb begin
    if (glyph_wen_r) begin
      glyph_wdata_s = merge_slice(ch_t_rw_data_i, slice_r, wdata_r);
    end else begin
      glyph_wdata_s = 128'h0;
    end
  end

  assign ready_o        = ready_r;
  assign rsp_valid_o    = rsp_valid_r;
  assign rsp_err_o      = rsp_err_r;
  assign rdata_o        = rdata_s;
  assign ch_map_addr_o  = ch_addr_r;
  assign ch_map_data_o  = ch_data_r;
  assign ch_map_wen_o   = ch_wen_r;
  assign col_map_addr_o = col_addr_r;
  assign col_map_data_o = col_data_r;
  assign col_map_wen_o  = col_wen_r;
  assign ch_t_rw_addr_o = glyph_addr_r;
  assign ch_t_rw_data_o = glyph_wdata_s;
  assign ch_t_rw_wen_o  = glyph_wen_r;
  assign fill_busy_o    = fill_busy_r;

endmodule

// File: tb/tb_vgachargen_mem_ctrl.sv
// Bench for vgachargen_mem_ctrl: BRAM models on port A, a transaction-level
// reference model with a per-cycle compare process, and directed scenarios.
module tb_vgachargen_mem_ctrl;

  logic         clk = 1'b0;
  logic         arstn = 1'b0;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic [13:0]  addr = 14'h0;
  logic [31:0]  wdata = 32'h0;
  logic         ready, rsp_valid, rsp_err;
  logic [31:0]  rdata;
  logic [11:0]  ch_addr, col_addr;
  logic [7:0]   ch_dout, col_dout, ch_din, col_din;
  logic         ch_wen, col_wen, gl_wen, busy;
  logic [6:0]   gl_addr;
  logic [127:0] gl_dout, gl_din;

  always #5 clk = ~clk;

  vgachargen_mem_ctrl dut (
    .clk_i(clk), .arstn_i(arstn), .req_i(req), .ready_o(ready), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .rsp_valid_o(rsp_valid), .rdata_o(rdata),
    .rsp_err_o(rsp_err),
    .ch_map_addr_o(ch_addr), .ch_map_data_o(ch_dout), .ch_map_wen_o(ch_wen), .ch_map_data_i(ch_din),
    .col_map_addr_o(col_addr), .col_map_data_o(col_dout), .col_map_wen_o(col_wen), .col_map_data_i(col_din),
    .ch_t_rw_addr_o(gl_addr), .ch_t_rw_data_o(gl_dout), .ch_t_rw_wen_o(gl_wen), .ch_t_rw_data_i(gl_din),
    .fill_busy_o(busy)
  );

  // Read-first synchronous BRAMs on port A
  logic [7:0]   bram_ch  [0:4095];
  logic [7:0]   bram_col [0:4095];
  logic [127:0] bram_gl  [0:127];
  int edge_cnt = 0;

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    ch_din  = bram_ch[ch_addr];
    col_din = bram_col[col_addr];
    gl_din  = bram_gl[gl_addr];
    if (ch_wen === 1'b1) bram_ch[ch_addr] = ch_dout;
    if (col_wen === 1'b1) bram_col[col_addr] = col_dout;
    if (gl_wen === 1'b1) bram_gl[gl_addr] = gl_dout;
  end

  // Reference model: expected memory contents and per-edge expectations
  typedef struct { int e; logic [31:0] rd; logic err; } rsp_t;
  rsp_t         rq[$];
  logic [7:0]   exp_ch  [0:2399];
  logic [7:0]   exp_col [0:2399];
  logic [127:0] exp_gl  [0:127];
  int ready_from = 0, fill_start = -1, fill_end = -2;
  int ch_wr_edge = -1, col_wr_edge = -1, gl_wr_edge = -1, accept_edge = 0;
  int busy_cnt = 0, ck;
  int vectors = 0, fails = 0;
  logic [31:0] last_rdata = 32'h0;
  logic last_err = 1'b0;
  bit chk_en = 1'b0, exp_rsp, fa;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    fails++;
    $display("FAIL %s: wait bound expired at edge %0d", name, edge_cnt);
  endtask

  task automatic model_accept(input int n, input logic w, input logic [13:0] a, input logic [31:0] d);
    logic [1:0]  rg;
    logic [11:0] ofs;
    int g, s;
    bit ok;
    rg = a[13:12];
    ofs = a[11:0];
    g = int'(ofs[8:2]);
    s = int'(ofs[1:0]);
    accept_edge = n;
    ok = (rg == 2'd0 || rg == 2'd1) ? (ofs < 12'd2400) : (rg == 2'd2) ? (ofs < 12'd512) : (ofs == 12'd0);
    if (!ok) begin
      rq.push_back('{n, 32'h0, 1'b1});
      ready_from = n;
    end else if (rg == 2'd0 || rg == 2'd1) begin
      if (w) begin
        if (rg == 2'd0) begin exp_ch[ofs] = d[7:0]; ch_wr_edge = n; end
        else begin exp_col[ofs] = d[7:0]; col_wr_edge = n; end
        rq.push_back('{n, 32'h0, 1'b0});
        ready_from = n;
      end else begin
        rq.push_back('{n + 1, {24'h0, (rg == 2'd0) ? exp_ch[ofs] : exp_col[ofs]}, 1'b0});
        ready_from = n + 1;
      end
    end else if (rg == 2'd2) begin
      if (w) begin
        exp_gl[g][s*32 +: 32] = d;
        rq.push_back('{n + 1, 32'h0, 1'b0});
        gl_wr_edge = n + 1;
        ready_from = n + 2;
      end else begin
        rq.push_back('{n + 1, exp_gl[g][s*32 +: 32], 1'b0});
        ready_from = n + 1;
      end
    end else begin
      rq.push_back('{n, 32'h0, 1'b0});
      ready_from = n;
      if (w && d[16]) begin
        fill_start = n;
        fill_end   = n + 2399;
        ready_from = n + 2400;
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      ck = edge_cnt;
      exp_rsp = (rq.size() > 0) && (rq[0].e == ck);
      fa = (ck >= fill_start) && (ck <= fill_end);
      chk("rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp) begin
        chk("rdata", rdata, rq[0].rd);
        chk("rsp_err", rsp_err, rq[0].err);
        last_rdata = rdata;
        last_err = rsp_err;
        void'(rq.pop_front());
      end
      chk("ready", ready, ck >= ready_from);
      chk("fill_busy", busy, fa);
      chk("ch_wen", ch_wen, fa || ck == ch_wr_edge);
      chk("col_wen", col_wen, fa || ck == col_wr_edge);
      chk("glyph_wen", gl_wen, ck == gl_wr_edge);
      if (busy === 1'b1) busy_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); #1; end
  endtask

  task automatic issue(input logic w, input logic [13:0] a, input logic [31:0] d);
    bit done;
    done = 1'b0;
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int t = 0; t < 3000 && !done; t++) begin
      if (edge_cnt >= ready_from) begin
        model_accept(edge_cnt + 1, w, a, d);
        done = 1'b1;
      end
      step(1);
    end
    if (!done) timeout_fail("issue_accept");
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0;
    step(n);
  endtask

  task automatic do_reset(input int cyc);
    int r;
    r = edge_cnt + 1;
    ready_from = r;
    rq.delete();
    if (fill_end >= r) fill_end = r - 1;
    if (ch_wr_edge >= r) ch_wr_edge = -1;
    if (col_wr_edge >= r) col_wr_edge = -1;
    if (gl_wr_edge >= r) gl_wr_edge = -1;
    req = 1'b0;
    arstn = 1'b0;
    step(cyc);
    arstn = 1'b1;
  endtask

  task automatic apply_fill(input int cnt, input logic [7:0] c, input logic [7:0] col);
    for (int i = 0; i < cnt; i++) begin exp_ch[i] = c; exp_col[i] = col; end
  endtask

  task automatic check_arrays(input string tag);
    int m_ch, m_col, m_gl;
    m_ch = 0; m_col = 0; m_gl = 0;
    for (int i = 0; i < 2400; i++) begin
      if (bram_ch[i] !== exp_ch[i]) m_ch++;
      if (bram_col[i] !== exp_col[i]) m_col++;
    end
    for (int i = 0; i < 128; i++) if (bram_gl[i] !== exp_gl[i]) m_gl++;
    chk({tag, "_ch_map_diffs"}, m_ch, 0);
    chk({tag, "_col_map_diffs"}, m_col, 0);
    chk({tag, "_glyph_diffs"}, m_gl, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin bram_ch[i] = 8'h00; bram_col[i] = 8'h00; end
    for (int i = 0; i < 2400; i++) begin exp_ch[i] = 8'h00; exp_col[i] = 8'h00; end
    for (int i = 0; i < 128; i++) begin
      bram_gl[i] = (i == 5) ? {128{1'b1}} : 128'h0;
      exp_gl[i]  = (i == 5) ? {128{1'b1}} : 128'h0;
    end
    step(3);
    arstn = 1'b1;
    chk_en = 1'b1;
    step(1);

    // Map write then read back
    issue(1'b1, 14'h0010, 32'h0000_0041);
    issue(1'b0, 14'h0010, 32'h0);
    idle(2);
    chk("readback_0x41", last_rdata, 32'h41);
    chk("readback_err", last_err, 1'b0);

    // Out-of-range colour map write
    issue(1'b1, 14'h1960, 32'h0000_00AB);
    idle(2);
    chk("oob_err", last_err, 1'b1);
    chk("oob_rdata", last_rdata, 32'h0);
    chk("oob_no_write", bram_col[2400], 8'h00);

    // Glyph RMW of slice 2 in row 5, then read slices 2 and 1
    issue(1'b1, 14'h2016, 32'h0000_0000);
    idle(2);
    chk("glyph5_row", bram_gl[5], 128'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF);
    issue(1'b0, 14'h2016, 32'h0);
    issue(1'b0, 14'h2015, 32'h0);
    idle(2);
    chk("glyph5_slice1", last_rdata, 32'hFFFF_FFFF);

    // Control read, bad control offset, out-of-range glyph offset
    issue(1'b0, 14'h3000, 32'h0);
    issue(1'b0, 14'h3001, 32'h0);
    issue(1'b1, 14'h2200, 32'h1234_5678);
    issue(1'b1, 14'h3000, 32'h0000_1F20);
    idle(2);

    // Back-to-back with req held high
    issue(1'b1, 14'h0001, 32'h0000_0011);
    issue(1'b1, 14'h1001, 32'h0000_0022);
    issue(1'b0, 14'h0001, 32'h0);
    issue(1'b1, 14'h0002, 32'h0000_0033);
    issue(1'b1, 14'h201C, 32'hDEAD_BEEF);
    issue(1'b0, 14'h1001, 32'h0);
    idle(3);
    chk("b2b_last_read", last_rdata, 32'h22);
    check_arrays("pre_fill");

    // Full-screen fill
    busy_cnt = 0;
    issue(1'b1, 14'h3000, 32'h0001_1F20);
    idle(2402);
    apply_fill(2400, 8'h20, 8'h1F);
    chk("fill_busy_cycles", busy_cnt, 2400);
    chk("fill_ch_first", bram_ch[0], 8'h20);
    chk("fill_col_last", bram_col[2399], 8'h1F);
    check_arrays("fill");

    // Fill aborted by reset after index 999 has been written
    issue(1'b1, 14'h3000, 32'h0001_072A);
    req = 1'b0;
    for (int t = 0; t < 3000 && edge_cnt < accept_edge + 999; t++) step(1);
    if (edge_cnt != accept_edge + 999) timeout_fail("abort_wait");
    do_reset(1);
    apply_fill(1000, 8'h2A, 8'h07);
    idle(3);
    chk("abort_ch_999", bram_ch[999], 8'h2A);
    chk("abort_col_999", bram_col[999], 8'h07);
    chk("abort_ch_1000", bram_ch[1000], 8'h20);
    check_arrays("abort");

    // Normal operation after the abort
    issue(1'b1, 14'h0005, 32'h0000_0055);
    issue(1'b0, 14'h0005, 32'h0);
    idle(3);
    chk("post_reset_read", last_rdata, 32'h55);
    check_arrays("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
